// File: rtl/hamming_secded_dec_if.sv
// Stream bundle between a codeword source, the SECDED decoder and the data consumer.
// The handshake semantics are documented once, in the header of hamming_secded_dec.sv.
interface hamming_secded_dec_if #(
  parameter int K = 4
);
  function automatic int calc_r(input int k);
    int r;
    r = 7;
    for (int i = 7; i >= 1; i--) begin
      if ((1 << i) >= k + i + 1) r = i;
    end
    return r;
  endfunction

  localparam int R = calc_r(K);
  localparam int N = K + R + 1;

  logic         in_valid;
  logic         in_ready;
  logic [N:1]   cw_in;
  logic         correct_en;
  logic         out_valid;
  logic         out_ready;
  logic [K:1]   data_out;
  logic         err_corr;
  logic         err_dbl;

  modport master (
    output in_valid, cw_in, correct_en, out_ready,
    input  in_ready, out_valid, data_out, err_corr, err_dbl
  );

  modport slave (
    input  in_valid, cw_in, correct_en, out_ready,
    output in_ready, out_valid, data_out, err_corr, err_dbl
  );
endinterface

// File: rtl/hamming_secded_dec.sv
// Two-stage Hamming SECDED decoder with valid/ready streaming and saturating error counters.
// Handshake: a transfer happens on a rising edge where valid && ready; once out_valid is high the result holds until out_ready.
module hamming_secded_dec #(
  parameter int K     = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk_dec,
  input  logic                  rst_dec,
  hamming_secded_dec_if.slave   dec_bus,
  input  logic                  clr_cnt,
  output logic [CNT_W-1:0]      corr_cnt,
  output logic [CNT_W-1:0]      dbl_cnt
);
  function automatic int calc_r(input int k);
    int r;
    r = 7;
    for (int i = 7; i >= 1; i--) begin
      if ((1 << i) >= k + i + 1) r = i;
    end
    return r;
  endfunction

  localparam int R = calc_r(K);
  localparam int N = K + R + 1;

  function automatic logic [R-1:0] syndrome(input logic [N:1] cw);
    logic [R-1:0] s;
    s = '0;
    for (int p = 1; p <= K + R; p++) begin
      for (int j = 0; j < R; j++) begin
        if (((p >> j) & 1) != 0) s[j] = s[j] ^ cw[p];
      end
    end
    return s;
  endfunction

  // Data occupies every non-power-of-two position, in ascending order.
  function automatic logic [K:1] extract(input logic [N:1] cw);
    logic [K:1] d;
    int         di;
    d  = '0;
    di = 1;
    for (int p = 1; p <= K + R; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[di] = cw[p];
        di++;
      end
    end
    return d;
  endfunction

  logic             v1_q;
  logic [N:1]       cw1_q;
  logic             ce1_q;
  logic [R-1:0]     s1_q;
  logic             p1_q;

  logic             out_valid_q;
  logic [K:1]       data_q;
  logic             corr_q;
  logic             dbl_q;

  logic [K:1]       data_d;
  logic             corr_d;
  logic             dbl_d;
  logic [N:1]       cw_fix;
  int               s_int;

  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0] dbl_cnt_q, dbl_cnt_d;

  logic             advance;
  logic             deliver;

  // Both stages move together; a stalled output freezes the whole pipe.
  assign advance = !(out_valid_q && !dec_bus.out_ready);
  assign deliver = out_valid_q && dec_bus.out_ready;

  assign dec_bus.in_ready  = advance;
  assign dec_bus.out_valid = out_valid_q;
  assign dec_bus.data_out  = data_q;
  assign dec_bus.err_corr  = corr_q;
  assign dec_bus.err_dbl   = dbl_q;
  assign corr_cnt          = corr_cnt_q;
  assign dbl_cnt           = dbl_cnt_q;

  always_comb begin
    cw_fix = cw1_q;
    corr_d = 1'b0;
    dbl_d  = 1'b0;
    s_int  = int'(s1_q);
    if (p1_q) begin
      if (s_int == 0) begin
        corr_d = 1'b1;
      end else if (s_int <= K + R) begin
        corr_d = 1'b1;
        if (ce1_q) begin
          for (int p = 1; p <= K + R; p++) begin
            if (p == s_int) cw_fix[p] = ~cw_fix[p];
          end
        end
      end else begin
        dbl_d = 1'b1;
      end
    end else if (s_int != 0) begin
      dbl_d = 1'b1;
    end
    data_d = extract(cw_fix);
  end

  always_ff @(posedge clk_dec) begin
    if (rst_dec) begin
      v1_q        <= 1'b0;
      cw1_q       <= '0;
      ce1_q       <= 1'b0;
      s1_q        <= '0;
      p1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      corr_q      <= 1'b0;
      dbl_q       <= 1'b0;
    end else if (advance) begin
      v1_q        <= dec_bus.in_valid;
      out_valid_q <= v1_q;
      if (dec_bus.in_valid) begin
        cw1_q <= dec_bus.cw_in;
        ce1_q <= dec_bus.correct_en;
        s1_q  <= syndrome(dec_bus.cw_in);
        p1_q  <= ^dec_bus.cw_in;
      end
      if (v1_q) begin
        data_q <= data_d;
        corr_q <= corr_d;
        dbl_q  <= dbl_d;
      end
    end
  end

  // Clear wins over a simultaneous delivery; counts stick at all-ones.
  always_comb begin
    corr_cnt_d = corr_cnt_q;
    dbl_cnt_d  = dbl_cnt_q;
    if (clr_cnt) begin
      corr_cnt_d = '0;
      dbl_cnt_d  = '0;
    end else if (deliver) begin
      if (corr_q && (corr_cnt_q != '1)) corr_cnt_d = corr_cnt_q + 1'b1;
      if (dbl_q && (dbl_cnt_q != '1))   dbl_cnt_d  = dbl_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_dec) begin
    if (rst_dec) begin
      corr_cnt_q <= '0;
      dbl_cnt_q  <= '0;
    end else begin
      corr_cnt_q <= corr_cnt_d;
      dbl_cnt_q  <= dbl_cnt_d;
    end
  end
endmodule

// File: tb/tb_hamming_secded_dec.sv
// Bench for hamming_secded_dec (K=4, CNT_W=2): an error-injection model feeds an expected queue drained by a monitor.
module tb_hamming_secded_dec;
  localparam int K     = 4;
  localparam int R     = 3;
  localparam int N     = K + R + 1;
  localparam int CNT_W = 2;
  localparam int EW    = K + 2;

  logic             clk_dec;
  logic             rst_dec;
  logic             clr_cnt;
  logic [CNT_W-1:0] corr_cnt;
  logic [CNT_W-1:0] dbl_cnt;

  hamming_secded_dec_if #(.K(K)) bus ();

  hamming_secded_dec #(.K(K), .CNT_W(CNT_W)) dut (
    .clk_dec  (clk_dec),
    .rst_dec  (rst_dec),
    .dec_bus  (bus),
    .clr_cnt  (clr_cnt),
    .corr_cnt (corr_cnt),
    .dbl_cnt  (dbl_cnt)
  );

  int checks = 0;
  int errors = 0;
  logic [EW-1:0]    exp_q[$];
  logic [CNT_W-1:0] exp_corr = '0;
  logic [CNT_W-1:0] exp_dbl  = '0;
  logic             bp_en    = 1'b0;

  // clock / reset
  initial clk_dec = 1'b0;
  always #5 clk_dec = ~clk_dec;

  // model
  function automatic logic [N:1] encode(input logic [K:1] d);
    logic [N:1] cw;
    logic       par;
    int         di;
    cw = '0;
    di = 1;
    for (int p = 1; p <= K + R; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p] = d[di];
        di++;
      end
    end
    for (int j = 0; j < R; j++) begin
      par = 1'b0;
      for (int p = 1; p <= K + R; p++) begin
        if (((p & (p - 1)) != 0) && (((p >> j) & 1) != 0)) par = par ^ cw[p];
      end
      cw[1 << j] = par;
    end
    cw[N] = ^cw[N-1:1];
    return cw;
  endfunction

  function automatic logic [K:1] extract(input logic [N:1] cw);
    logic [K:1] d;
    int         di;
    d  = '0;
    di = 1;
    for (int p = 1; p <= K + R; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[di] = cw[p];
        di++;
      end
    end
    return d;
  endfunction

  // Expected result from the injected error pattern, not from a syndrome.
  function automatic logic [EW-1:0] calc_exp(input logic [K:1] d, input logic [N:1] mask, input logic ce);
    logic [N:1] bad;
    int         n;
    bad = encode(d) ^ mask;
    n   = $countones(mask);
    if (n == 0) return {d, 2'b00};
    if (n == 1) begin
      if (mask[N]) return {d, 2'b10};
      return {(ce ? d : extract(bad)), 2'b10};
    end
    return {extract(bad), 2'b01};
  endfunction

  function automatic logic [N:1] rand_mask(input int nflip);
    logic [N:1] m;
    int         a;
    int         b;
    m = '0;
    a = $urandom_range(1, N);
    b = a + $urandom_range(1, N - 1);
    if (b > N) b = b - N;
    if (nflip >= 1) m[a] = 1'b1;
    if (nflip >= 2) m[b] = 1'b1;
    return m;
  endfunction

  // scoreboard monitor
  always @(negedge clk_dec) begin
    logic [EW-1:0] e;
    logic [EW-1:0] got;
    if (rst_dec) begin
      exp_corr = '0;
      exp_dbl  = '0;
    end else begin
      e = '0;
      if (bus.out_valid && bus.out_ready) begin
        got = {bus.data_out, bus.err_corr, bus.err_dbl};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard unexpected output got=%b", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL scoreboard data/corr/dbl got=%b exp=%b", got, e);
          end
        end
      end
      if (clr_cnt) begin
        exp_corr = '0;
        exp_dbl  = '0;
      end else if (bus.out_valid && bus.out_ready) begin
        if (e[1] && exp_corr != '1) exp_corr = exp_corr + 1'b1;
        if (e[0] && exp_dbl != '1)  exp_dbl  = exp_dbl + 1'b1;
      end
    end
  end

  always @(posedge clk_dec) begin
    if (bp_en) begin
      #1 bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  // driver tasks
  task automatic send(input logic [N:1] cw, input logic ce, input logic [EW-1:0] e);
    int g;
    g = 0;
    bus.in_valid   = 1'b1;
    bus.cw_in      = cw;
    bus.correct_en = ce;
    @(negedge clk_dec);
    while (!bus.in_ready && g < 100) begin
      @(negedge clk_dec);
      g++;
    end
    if (g >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout in_ready=%b required=1", bus.in_ready);
    end
    @(posedge clk_dec);
    exp_q.push_back(e);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(negedge clk_dec);
      g++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk_dec);
    #1;
  endtask

  task automatic check_cnt(input string name, input logic [CNT_W-1:0] c_req, input logic [CNT_W-1:0] d_req);
    checks++;
    if (corr_cnt !== c_req || corr_cnt !== exp_corr) begin
      errors++;
      $display("FAIL %s corr_cnt=%0d required=%0d model=%0d", name, corr_cnt, c_req, exp_corr);
    end
    checks++;
    if (dbl_cnt !== d_req || dbl_cnt !== exp_dbl) begin
      errors++;
      $display("FAIL %s dbl_cnt=%0d required=%0d model=%0d", name, dbl_cnt, d_req, exp_dbl);
    end
  endtask

  // tests
  task automatic test_reset();
    rst_dec = 1'b1;
    repeat (2) @(posedge clk_dec);
    @(negedge clk_dec);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++;
    if (bus.data_out !== '0) begin errors++; $display("FAIL reset_data_out got=%b exp=0", bus.data_out); end
    checks++;
    if (bus.err_corr !== 1'b0 || bus.err_dbl !== 1'b0) begin
      errors++; $display("FAIL reset_flags corr=%b dbl=%b exp=0/0", bus.err_corr, bus.err_dbl);
    end
    checks++;
    if (corr_cnt !== '0 || dbl_cnt !== '0) begin
      errors++; $display("FAIL reset_counters corr=%0d dbl=%0d exp=0/0", corr_cnt, dbl_cnt);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    @(posedge clk_dec);
    #1 rst_dec = 1'b0;
  endtask

  task automatic test_vectors();
    bus.out_ready = 1'b1;
    send(8'b01010101, 1'b1, {4'b1011, 2'b00});
    send(8'b01010001, 1'b1, {4'b1011, 2'b10});
    send(8'b01010001, 1'b0, {4'b1010, 2'b10});
    send(8'b11010101, 1'b1, {4'b1011, 2'b10});
    send(8'b01000001, 1'b1, {4'b1000, 2'b01});
    drain();
    check_cnt("vectors_cnt", 2'd3, 2'd1);
  endtask

  task automatic test_backpressure();
    logic [N:1]    words[4];
    logic [EW-1:0] exps[4];
    logic [EW-1:0] held;
    logic          acc;
    int            idx;
    int            stall;
    int            g;
    idx   = 0;
    stall = 0;
    g     = 0;
    held  = '0;
    for (int i = 0; i < 4; i++) begin
      logic [N:1] m;
      logic [K:1] d;
      d        = K'(i * 5 + 3);
      m        = rand_mask(i % 3);
      words[i] = encode(d) ^ m;
      exps[i]  = calc_exp(d, m, 1'b1);
    end
    bus.out_ready  = 1'b0;
    bus.in_valid   = 1'b1;
    bus.cw_in      = words[0];
    bus.correct_en = 1'b1;
    while ((idx < 4 || exp_q.size() != 0) && g < 60) begin
      @(negedge clk_dec);
      g++;
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid && !bus.out_ready) begin
        if (stall == 0) begin
          held = {bus.data_out, bus.err_corr, bus.err_dbl};
        end else begin
          checks++;
          if ({bus.data_out, bus.err_corr, bus.err_dbl} !== held) begin
            errors++;
            $display("FAIL stall_stable got=%b held=%b", {bus.data_out, bus.err_corr, bus.err_dbl}, held);
          end
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%b exp=0", bus.in_ready); end
        stall++;
      end
      @(posedge clk_dec);
      if (acc) begin
        exp_q.push_back(exps[idx]);
        idx++;
      end
      #1;
      if (idx < 4) bus.cw_in = words[idx];
      else bus.in_valid = 1'b0;
      if (stall >= 3) bus.out_ready = 1'b1;
    end
    checks++;
    if (g >= 60 || stall < 3) begin
      errors++;
      $display("FAIL backpressure_progress cycles=%0d stalls=%0d required_stalls=3", g, stall);
      exp_q.delete();
    end
    bus.in_valid = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rv;
    logic [K:1]  d;
    logic [N:1]  m;
    logic        ce;
    bp_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rv = $urandom();
      d  = rv[K:1];
      ce = rv[8];
      m  = rand_mask($urandom_range(0, 2));
      send(encode(d) ^ m, ce, calc_exp(d, m, ce));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk_dec);
        #1;
      end
    end
    bp_en = 1'b0;
    @(posedge clk_dec);
    #2 bus.out_ready = 1'b1;
    drain();
    check_cnt("random_cnt", exp_corr, exp_dbl);
  endtask

  task automatic test_counters();
    logic [N:1] m;
    int         g;
    clr_cnt = 1'b1;
    @(posedge clk_dec);
    #1 clr_cnt = 1'b0;
    check_cnt("clear_cnt", 2'd0, 2'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      m = '0;
      m[$urandom_range(1, K + R)] = 1'b1;
      send(encode(K'(i + 6)) ^ m, 1'b1, calc_exp(K'(i + 6), m, 1'b1));
    end
    drain();
    check_cnt("saturate_cnt", 2'd3, 2'd0);
    bus.out_ready = 1'b0;
    m = '0;
    m[5] = 1'b1;
    send(encode(4'b0110) ^ m, 1'b1, {4'b0110, 2'b10});
    g = 0;
    while (!bus.out_valid && g < 20) begin
      @(posedge clk_dec);
      #1;
      g++;
    end
    checks++;
    if (!bus.out_valid) begin errors++; $display("FAIL sixth_word_timeout out_valid=%b exp=1", bus.out_valid); end
    bus.out_ready = 1'b1;
    clr_cnt       = 1'b1;
    @(posedge clk_dec);
    #1 clr_cnt = 1'b0;
    check_cnt("clr_priority_cnt", 2'd0, 2'd0);
    drain();
  endtask

  task automatic test_reset_mid();
    logic [N:1] m;
    bus.out_ready = 1'b1;
    m = '0;
    m[3] = 1'b1;
    send(encode(4'b1001) ^ m, 1'b1, {4'b1001, 2'b10});
    drain();
    check_cnt("pre_reset_cnt", 2'd1, 2'd0);
    send(encode(4'b0011), 1'b1, {4'b0011, 2'b00});
    send(encode(4'b1100), 1'b1, {4'b1100, 2'b00});
    rst_dec = 1'b1;
    @(posedge clk_dec);
    #1 rst_dec = 1'b0;
    exp_q.delete();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_out_valid got=%b exp=0", bus.out_valid); end
    check_cnt("mid_reset_cnt", 2'd0, 2'd0);
    repeat (3) @(negedge clk_dec);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle got=%b exp=0", bus.out_valid); end
    @(posedge clk_dec);
    #1;
  endtask

  initial begin
    rst_dec        = 1'b1;
    clr_cnt        = 1'b0;
    bus.in_valid   = 1'b0;
    bus.cw_in      = '0;
    bus.correct_en = 1'b1;
    bus.out_ready  = 1'b1;
    test_reset();
    test_vectors();
    test_backpressure();
    test_back_to_back();
    test_counters();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
